// File: rtl/maxpool_window_buffer_pkg.sv
//==============================================================================
// Module      : maxpool_window_buffer_pkg
// Description : Shared state encoding, pooling-stage state code and the
//               channel-interleave helper for the 2x2 window former.
// Revision    : 1.0
//==============================================================================
`default_nettype none

`ifndef CHANNEL_OUT
`define CHANNEL_OUT 2
`endif

package maxpool_window_buffer_pkg;

  localparam int CH    = `CHANNEL_OUT;
  localparam int PIX_W = CH * 8;

  localparam logic [2:0] POOL_STATE_ACTIVE = 3'd4;

  typedef enum logic [1:0] {
    FILL_EVEN = 2'd0,
    PAIR_ODD  = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  // Per channel: left pixel byte in the low half, right pixel byte in the high half.
  function automatic logic [2*PIX_W-1:0] interleave(input logic [PIX_W-1:0] left,
                                                   input logic [PIX_W-1:0] right);
    logic [2*PIX_W-1:0] res;
    res = '0;
    for (int i = 0; i < CH; i++) begin
      res[16*i +: 8]     = left[8*i +: 8];
      res[16*i + 8 +: 8] = right[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_window_buffer_line_buffer.sv
//==============================================================================
// Module      : pool_line_buffer
// Description : IMG_W-deep single-write-port line store with two combinational
//               read ports; holds the even row awaiting its odd partner.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pool_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  // Contents are don't-care after reset, so the array is left unreset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/maxpool_window_buffer.sv
//==============================================================================
// Module      : maxpool_window_buffer
// Description : Streaming 2x2 stride-2 window former feeding the max-pool stage.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module maxpool_window_buffer
  import maxpool_window_buffer_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*PIX_W-1:0] pixel_1and2,
  output logic [PIX_W-1:0]   pixel_3,
  output logic [PIX_W-1:0]   pixel_4,
  output logic [2:0]         curr_state_or,
  output logic               frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
    $error("maxpool_window_buffer: IMG_W and IMG_H must be even and >= 2");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [PIX_W-1:0]   left_q, left_d;
  logic               valid_q, valid_d;
  logic [2*PIX_W-1:0] p12_q, p12_d;
  logic [PIX_W-1:0]   p3_q, p3_d;
  logic [PIX_W-1:0]   p4_q, p4_d;
  logic               fd_q, fd_d;

  logic               buf_we;
  logic [PIX_W-1:0]   rd_left, rd_right;
  logic               xfer_in, xfer_out, load;

  assign in_ready = (state_q != FLUSH) && (!valid_q || out_ready);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = valid_q && out_ready;
  assign load     = xfer_in && (state_q == PAIR_ODD) && col_q[0];

  pool_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (CW)
  ) u_line_buf (
    .clk       (clk),
    .we_i      (buf_we),
    .waddr_i   (col_q),
    .wdata_i   (in_pixel),
    .raddr_a_i ({col_q[CW-1:1], 1'b0}),
    .raddr_b_i (col_q),
    .rdata_a_o (rd_left),
    .rdata_b_o (rd_right)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    left_d  = left_q;
    valid_d = valid_q;
    p12_d   = p12_q;
    p3_d    = p3_q;
    p4_d    = p4_q;
    fd_d    = 1'b0;
    buf_we  = 1'b0;

    // A load in the same cycle as a consume keeps the window stream unbroken.
    if (load) begin
      p12_d   = interleave(rd_left, rd_right);
      p3_d    = left_q;
      p4_d    = in_pixel;
      valid_d = 1'b1;
    end else if (xfer_out) begin
      valid_d = 1'b0;
    end

    case (state_q)
      FILL_EVEN: begin
        if (xfer_in) begin
          buf_we = 1'b1;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = row_q + RW'(1);
            state_d = PAIR_ODD;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      PAIR_ODD: begin
        if (xfer_in) begin
          if (!col_q[0]) begin
            left_d = in_pixel;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = FLUSH;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = FILL_EVEN;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (xfer_out) begin
          fd_d    = 1'b1;
          col_d   = '0;
          row_d   = '0;
          state_d = FILL_EVEN;
        end
      end
      default: state_d = FILL_EVEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_EVEN;
      col_q   <= '0;
      row_q   <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      p12_q   <= '0;
      p3_q    <= '0;
      p4_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      p12_q   <= p12_d;
      p3_q    <= p3_d;
      p4_q    <= p4_d;
      fd_q    <= fd_d;
    end
  end

  assign out_valid     = valid_q;
  assign pixel_1and2   = p12_q;
  assign pixel_3       = p3_q;
  assign pixel_4       = p4_q;
  assign frame_done    = fd_q;
  assign curr_state_or = valid_q ? POOL_STATE_ACTIVE : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_window_buffer.sv
//==============================================================================
// Module      : tb_maxpool_window_buffer
// Description : Self-checking bench: 4x4 instance against a frame-level model,
//               2x2 instance with literal window expectations.
// Revision    : 1.0
//==============================================================================
`default_nettype none

`ifndef CHANNEL_OUT
`define CHANNEL_OUT 2
`endif

module tb_maxpool_window_buffer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, fd;
  logic [15:0] in_pixel, p3, p4;
  logic [31:0] p12;
  logic [2:0]  cso;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_fd;
  logic [15:0] s_in_pixel, s_p3, s_p4;
  logic [31:0] s_p12;
  logic [2:0]  s_cso;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit run_cmp = 0;

  maxpool_window_buffer #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_1and2(p12), .pixel_3(p3),
    .pixel_4(p4), .curr_state_or(cso), .frame_done(fd)
  );

  maxpool_window_buffer #(.IMG_W(2), .IMG_H(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .pixel_1and2(s_p12), .pixel_3(s_p3),
    .pixel_4(s_p4), .curr_state_or(s_cso), .frame_done(s_fd)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level reference model for the 4x4 instance --------
  logic [15:0] top_row [W];
  logic [15:0] m_bl = '0;
  int          m_acc = 0;
  int          m_frames = 0;
  bit          m_valid = 0;
  bit          m_fd = 0;
  logic [31:0] m_p12 = '0;
  logic [15:0] m_p3 = '0;
  logic [15:0] m_p4 = '0;

  function automatic logic [31:0] build12(input logic [15:0] tl, input logic [15:0] tr);
    return {tr[15:8], tl[15:8], tr[7:0], tl[7:0]};
  endfunction

  function automatic bit m_in_ready();
    return (m_acc != N) && (!m_valid || out_ready);
  endfunction

  initial forever begin
    bit xin, xout, loaded;
    int r, c;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_acc = 0; m_valid = 0; m_fd = 0; m_p12 = '0; m_p3 = '0; m_p4 = '0;
    end else begin
      xin    = in_valid && m_in_ready();
      xout   = m_valid && out_ready;
      m_fd   = (m_acc == N) && xout;
      loaded = 0;
      if (xin) begin
        r = m_acc / W;
        c = m_acc % W;
        m_acc++;
        if (r % 2 == 0) top_row[c] = in_pixel;
        else if (c % 2 == 0) m_bl = in_pixel;
        else begin
          m_p12 = build12(top_row[c-1], top_row[c]);
          m_p3 = m_bl;
          m_p4 = in_pixel;
          m_valid = 1;
          loaded = 1;
        end
      end
      if (!loaded && xout) m_valid = 0;
      if (m_fd) begin
        m_acc = 0;
        m_frames++;
      end
    end
  end

  typedef struct {
    logic [31:0] p12;
    logic [15:0] p3;
    logic [15:0] p4;
    int          cyc;
  } win_t;
  win_t win_log[$];

  // Every-cycle comparison of the 4x4 instance against the model.
  initial forever begin
    win_t w;
    @(negedge clk);
    if (run_cmp) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_valid);
      chk("curr_state_or", cso, m_valid ? 3'd4 : 3'd0);
      chk("frame_done", fd, m_fd);
      if (rst || m_valid) begin
        chk("pixel_1and2", p12, m_p12);
        chk("pixel_3", p3, m_p3);
        chk("pixel_4", p4, m_p4);
      end
      if (out_valid && out_ready) begin
        w.p12 = p12; w.p3 = p3; w.p4 = p4; w.cyc = cyc;
        win_log.push_back(w);
      end
    end
  end

  task automatic send(input bit sel, input logic [15:0] p);
    bit done;
    done = 0;
    if (sel) begin s_in_valid = 1; s_in_pixel = p; end
    else begin in_valid = 1; in_pixel = p; end
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (sel ? s_in_ready : in_ready) begin
        @(posedge clk);
        #2;
        if (sel) s_in_valid = 0; else in_valid = 0;
        done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout actual=stalled required=accepted pixel=%0h", p);
      if (sel) s_in_valid = 0; else in_valid = 0;
    end
  endtask

  function automatic logic [15:0] rpix();
    logic [15:0] v;
    for (int b = 0; b < 2; b++) begin
      case ($urandom % 8)
        0: v[8*b +: 8] = 8'h80;
        1: v[8*b +: 8] = 8'h7F;
        2: v[8*b +: 8] = 8'hFF;
        3: v[8*b +: 8] = 8'h00;
        default: v[8*b +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic chk_small(input logic [31:0] e12, input logic [15:0] e3, input logic [15:0] e4);
    @(negedge clk);
    chk("s_out_valid", s_out_valid, 1);
    chk("s_curr_state_or", s_cso, 3'd4);
    chk("s_pixel_1and2", s_p12, e12);
    chk("s_pixel_3", s_p3, e3);
    chk("s_pixel_4", s_p4, e4);
    @(negedge clk);
    chk("s_frame_done", s_fd, 1);
    chk("s_out_valid_after", s_out_valid, 0);
    @(negedge clk);
    chk("s_frame_done_pulse", s_fd, 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1;
    in_valid = 0; in_pixel = '0; out_ready = 0;
    s_in_valid = 0; s_in_pixel = '0; s_out_ready = 0;
    @(posedge clk);
    run_cmp = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_frame_done", s_fd, 0);
    chk("rst_state_or", s_cso, 0);
    chk("rst_p12", s_p12, 0);
    chk("rst_p3", s_p3, 0);
    chk("rst_p4", s_p4, 0);
    @(posedge clk);
    #2;
    rst = 0;

    // Basic 2x2 window, then signed extremes on the same instance.
    s_out_ready = 1;
    send(1, 16'h0201); send(1, 16'h0403); send(1, 16'h0605); send(1, 16'h0807);
    chk_small(32'h0402_0301, 16'h0605, 16'h0807);
    send(1, 16'h807F); send(1, 16'hFF80); send(1, 16'h7FFF); send(1, 16'h0080);
    chk_small(32'hFF80_807F, 16'h7FFF, 16'h0080);

    // Raster pairing on the first two rows of the 4x4 frame.
    out_ready = 1;
    win_log.delete();
    for (int k = 1; k <= 8; k++) send(0, 16'(k));
    repeat (3) @(posedge clk);
    #2;
    chk("raster_count", win_log.size(), 2);
    if (win_log.size() >= 2) begin
      chk("raster_w0_p12", win_log[0].p12, 32'h0000_0201);
      chk("raster_w0_p3", win_log[0].p3, 16'h0005);
      chk("raster_w0_p4", win_log[0].p4, 16'h0006);
      chk("raster_w1_p12", win_log[1].p12, 32'h0000_0403);
      chk("raster_w1_p3", win_log[1].p3, 16'h0007);
      chk("raster_w1_p4", win_log[1].p4, 16'h0008);
      chk("back_to_back_gap", win_log[1].cyc - win_log[0].cyc, 2);
    end

    // Backpressure on the first window of rows 2/3.
    for (int k = 9; k <= 14; k++) send(0, 16'(k));
    out_ready = 0;
    in_valid = 1;
    in_pixel = 16'd15;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p12", p12, 32'h0000_0A09);
      chk("bp_p3", p3, 16'h000D);
      chk("bp_p4", p4, 16'h000E);
    end
    @(posedge clk);
    #2;
    out_ready = 1;
    send(0, 16'd15);
    send(0, 16'd16);
    repeat (4) @(posedge clk);
    #2;
    chk("bp_window_count", win_log.size(), 4);

    // Reset after three pixels of row 1, then a fresh frame.
    for (int k = 0; k < 7; k++) send(0, 16'h0020 + 16'(k));
    rst = 1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_state_or", cso, 0);
    chk("mrst_frame_done", fd, 0);
    chk("mrst_p12", p12, 0);
    chk("mrst_p3", p3, 0);
    chk("mrst_p4", p4, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    win_log.delete();
    for (int k = 0; k < N; k++) send(0, 16'h0040 + 16'(k));
    repeat (4) @(posedge clk);
    #2;
    chk("post_rst_count", win_log.size(), 4);
    if (win_log.size() >= 1) begin
      chk("post_rst_p12", win_log[0].p12, 32'h0000_4140);
      chk("post_rst_p3", win_log[0].p3, 16'h0044);
      chk("post_rst_p4", win_log[0].p4, 16'h0045);
    end

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      in_valid  = ($urandom % 4) != 0;
      in_pixel  = rpix();
      out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk);
    #2;
    in_valid = 0;
    out_ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("frames_seen", m_frames >= 10, 1);
    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
